// File: rtl/iob_ram_arb_pkg.sv
// Shared arbitration definitions for the byte-enable RAM arbiter.
// Build option: define IOB_RAM_ARB_RR_EN for round-robin, else fixed priority.
package iob_ram_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

`ifdef IOB_RAM_ARB_RR_EN
    localparam arb_mode_e ARB_MODE = ARB_RR;
`else
    localparam arb_mode_e ARB_MODE = ARB_FIXED;
`endif

    localparam int N_REQ_MAX = 8;

    // Width of the last-grant pointer; never below one bit.
    function automatic int lg_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LG_W_MAX = lg_w(N_REQ_MAX);

endpackage

// File: rtl/iob_ram_arb_sel.sv
// One-hot grant selection from request vector and last-grant pointer.
// Build option: IOB_RAM_ARB_RR_EN selects round-robin search from lg+1.
module iob_ram_arb_sel
    import iob_ram_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LG_W  = lg_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [LG_W-1:0]  lg_i,
    output logic [N_REQ-1:0] grant_o
);

`ifdef IOB_RAM_ARB_RR_EN
    logic [LG_W:0]   sum;
    logic [LG_W-1:0] idx;
    logic            found;

    // Search starts one past the last winner and wraps modulo N_REQ.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, lg_i} + (LG_W+1)'(k);
            if (sum >= (LG_W+1)'(N_REQ))
                sum = sum - (LG_W+1)'(N_REQ);
            idx = sum[LG_W-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`else
    logic unused_lg;
    assign unused_lg = ^lg_i;

    // Lowest requesting index wins.
    always_comb begin
        grant_o = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/iob_ram_be_arb.sv
// N-requester arbiter in front of one single-port byte-write RAM.
// Build option: IOB_RAM_ARB_RR_EN enables round-robin arbitration.
module iob_ram_be_arb
    import iob_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [DATA_W-1:0]          resp_rdata,
    input  logic                       resp_ready,
    output logic                       mem_en,
    output logic [DATA_W/8-1:0]        mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_din,
    input  logic [DATA_W-1:0]          mem_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LG_W   = lg_w(N_REQ);

    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [LG_W-1:0]  lg_q, lg_d;
    logic [LG_W-1:0]  acc_idx;
    logic             stall;
    logic             acc;

    iob_ram_arb_sel #(
        .N_REQ (N_REQ),
        .LG_W  (LG_W)
    ) u_sel (
        .req_i   (req_valid),
        .lg_i    (lg_q),
        .grant_o (grant)
    );

    // An unconsumed response blocks new accepts; reset blocks them too.
    assign stall      = (|resp_valid_q) && !resp_ready;
    assign req_ready  = (rst || stall) ? '0 : grant;
    assign accept     = req_valid & req_ready;
    assign acc        = |accept;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = mem_dout;

    // Steer the accepted requester's slices onto the RAM port.
    always_comb begin
        mem_en   = acc;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        acc_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                mem_we   = req_wstrb[i*STRB_W +: STRB_W];
                mem_addr = req_addr[i*ADDR_W +: ADDR_W];
                mem_din  = req_wdata[i*DATA_W +: DATA_W];
                acc_idx  = LG_W'(i);
            end
        end
    end

    // Response owner follows the accept; held while stalled.
    always_comb begin
        resp_valid_d = '0;
        lg_d         = lg_q;
        if (acc) begin
            resp_valid_d = accept;
            lg_d         = acc_idx;
        end else if (stall) begin
            resp_valid_d = resp_valid_q;
        end
    end

    // Response and last-grant state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= '0;
            lg_q         <= LG_W'(N_REQ - 1);
        end else begin
            resp_valid_q <= resp_valid_d;
            lg_q         <= lg_d;
        end
    end

endmodule

// File: tb/tb_iob_ram_be_arb.sv
// Directed bench for iob_ram_be_arb with a behavioural byte-write RAM.
// Contention expectations follow IOB_RAM_ARB_RR_EN when it is defined.
module tb_iob_ram_be_arb;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int SW = DW / 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_wstrb;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_ready;
    logic            mem_en;
    logic [SW-1:0]   mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;

    logic [DW-1:0]   ram [0:(1<<AW)-1];

    int nvec = 0;
    int nerr = 0;

    iob_ram_be_arb #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .N_REQ  (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_ready (resp_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first, byte-write RAM, dout held while en is low.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < SW; b++)
                if (mem_we[b])
                    ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = a;
        req_wstrb[i*SW +: SW]  = s;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // One accepted transaction; rdata checked only when known.
    task automatic single(input string tag, input int i, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [DW-1:0] d,
                          input logic chk_rd, input logic [DW-1:0] rd);
        drive(i, 1'b1, a, s, d);
        #1;
        chk({tag, ".ready"}, req_ready, 32'(1 << i));
        chk({tag, ".en"}, mem_en, 1);
        chk({tag, ".we"}, mem_we, s);
        chk({tag, ".addr"}, mem_addr, a);
        if (s != 0) chk({tag, ".din"}, mem_din, d);
        tick();
        drive(i, 1'b0, '0, '0, '0);
        #1;
        chk({tag, ".rvalid"}, resp_valid, 32'(1 << i));
        if (chk_rd) chk({tag, ".rdata"}, resp_rdata, rd);
        tick();
        chk({tag, ".rvalid_clr"}, resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]  exp_g;
        logic [N-1:0]  prev_g;
        logic [DW-1:0] exp_rd;

        rst        = 1'b1;
        req_valid  = '1;
        req_addr   = '0;
        req_wstrb  = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) tick();
        chk("rst.rvalid", resp_valid, 0);
        chk("rst.ready", req_ready, 0);
        chk("rst.en", mem_en, 0);
        chk("rst.we", mem_we, 0);

        req_valid = '0;
        rst       = 1'b0;
        tick();

        single("wr0", 0, 10'h005, 4'hF, 32'hDEADBEEF, 1'b0, '0);
        single("wr1", 1, 10'h010, 4'hF, 32'h11223344, 1'b0, '0);
        single("rd0", 0, 10'h005, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        single("bw1", 1, 10'h010, 4'b0010, 32'h0000AB00, 1'b1, 32'h11223344);
        single("rd1", 1, 10'h010, 4'h0, 32'h0, 1'b1, 32'h1122AB44);

        drive(0, 1'b1, 10'h005, 4'h0, 32'h0);
        drive(1, 1'b1, 10'h010, 4'h0, 32'h0);
        prev_g = '0;
        for (int c = 0; c < 4; c++) begin
`ifdef IOB_RAM_ARB_RR_EN
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1;
            chk($sformatf("cont%0d.ready", c), req_ready, exp_g);
            chk($sformatf("cont%0d.en", c), mem_en, 1);
            if (c > 0) begin
                exp_rd = prev_g[0] ? 32'hDEADBEEF : 32'h1122AB44;
                chk($sformatf("cont%0d.rvalid", c), resp_valid, prev_g);
                chk($sformatf("cont%0d.rdata", c), resp_rdata, exp_rd);
            end
            prev_g = exp_g;
            tick();
        end
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        tick();

        drive(0, 1'b1, 10'h005, 4'h0, 32'h0);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 10'h010, 4'h0, 32'h0);
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d.rvalid", c), resp_valid, 2'b01);
            chk($sformatf("bp%0d.rdata", c), resp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp%0d.ready", c), req_ready, 0);
            chk($sformatf("bp%0d.en", c), mem_en, 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.rel_ready", req_ready, 2'b10);
        chk("bp.rel_en", mem_en, 1);
        chk("bp.rel_addr", mem_addr, 10'h010);
        tick();
        drive(1, 1'b0, '0, '0, '0);
        #1;
        chk("bp.rvalid1", resp_valid, 2'b10);
        chk("bp.rdata1", resp_rdata, 32'h1122AB44);
        tick();

        drive(0, 1'b1, 10'h005, 4'h0, 32'h0);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        #1;
        chk("mrst.rvalid", resp_valid, 0);
        req_valid = 2'b11;
        #1;
        chk("mrst.ready", req_ready, 0);
        chk("mrst.en", mem_en, 0);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 10'h005, 4'h0, 32'h0);
        drive(1, 1'b1, 10'h010, 4'h0, 32'h0);
        #1;
        chk("mrst.no_resp", resp_valid, 0);
        chk("mrst.first_grant", req_ready, 2'b01);
        tick();
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        #1;
        chk("mrst.rvalid0", resp_valid, 2'b01);
        chk("mrst.rdata0", resp_rdata, 32'hDEADBEEF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
